bit_serial_sub: RTL



---
 rtl/bss_pkg.sv | 14 +
 rtl/fs_cell.sv | 17 +
 rtl/bit_serial_sub.sv | 109 ++++++++++
 3 files changed

// File: rtl/bss_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bss_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = a - b - r, bo = borrow out of this bit.
// Latency: combinational.
// Backpressure: none.
// Ports: a (minuend bit), b (subtrahend bit), r (borrow in), d (difference bit), bo (borrow out).
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic r,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ r;
    // Borrow when b exceeds a outright, or a==b and a borrow is pending.
    assign bo = (~a & b) | (~(a ^ b) & r);

endmodule

// File: rtl/bit_serial_sub.sv
// Bit-serial subtractor: D = A - B - bin (mod 2^W), one bit per clock, LSB first.
// Latency: W+1 edges from accepted start to the done pulse; busy covers edges k..k+W.
// Backpressure: none; start is only sampled in IDLE, requests while busy/done are dropped.
// Ports: clk, rst_n (async active-low), start, bin, A, B in; D, Bo (per-bit borrow,
//        Bo[W-1] = final borrow), busy, done (one-cycle pulse) out.
module bit_serial_sub
    import bss_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         bin,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] D,
    output logic [W-1:0] Bo,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(W - 1);

    state_t           state_q;
    state_t           state_d;
    logic [W-1:0]     a_s;
    logic [W-1:0]     b_s;
    logic             brw_q;
    logic [CNT_W-1:0] idx_q;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    assign last_bit = (idx_q == LAST_IDX);

    fs_cell u_fs_cell (
        .a  (a_s[idx_q]),
        .b  (b_s[idx_q]),
        .r  (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s   <= '0;
            b_s   <= '0;
            brw_q <= 1'b0;
            idx_q <= '0;
            D     <= '0;
            Bo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Operands are shadowed so later changes on A/B/bin cannot leak in.
                    if (start) begin
                        a_s   <= A;
                        b_s   <= B;
                        brw_q <= bin;
                        idx_q <= '0;
                        D     <= '0;
                        Bo    <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    D[idx_q]  <= cell_d;
                    Bo[idx_q] <= cell_bo;
                    brw_q     <= cell_bo;
                    idx_q     <= idx_q + CNT_W'(1);
                    if (last_bit) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
